pll_reconfig_ctrl: RTL
======================

# pll_reconfig_ctrl

APB initiator that drives the dynamic-reconfiguration port of the GPLL wrapper (APB_ADDR[4:0], APB_WDATA[15:0], APB_RDATA, APB_READY), which is currently tied off. It accepts single read/write/re-lock commands from a local controller and runs one APB transfer or one PLL reset/lock sequence per command. It returns one response per command, with status, and never hangs on a silent responder or a PLL that fails to lock.

## Interface
- APB_TIMEOUT, 64: max ACCESS cycles waiting for apb_ready before abort.
- RST_CYC, 16: cycles pll_rst is held high in a re-lock command.
- LOCK_TIMEOUT, 65535: max cycles waiting for synchronized lock after pll_rst release.
- apb_clk  in  1  sole clock; APB and command side.
- apb_rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_op  in  2  0=WRITE, 1=READ, 2=RELOCK, 3=reserved (completes as WRITE-less OK no-op).
- cmd_addr  in  5  register address.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0=OK, 1=APB_TIMEOUT, 2=LOCK_TIMEOUT.
- rsp_rdata  out  16  read data (0 for non-READ or on timeout).
- apb_sel, apb_en, apb_write  out  1 each  APB control to GPLL.
- apb_addr  out  5; apb_wdata  out  16.
- apb_rdata  in  16; apb_ready  in  1.
- pll_rst  out  1  to GPLL RST.
- pll_lock  in  1  GPLL LOCK, asynchronous to apb_clk.
- locked  out  1  synchronized lock level.

## Operation
- States: IDLE, SETUP, ACCESS, PRST, WLOCK, RESP.
- IDLE: cmd_ready=1. On handshake, latch op/addr/wdata; WRITE/READ -> SETUP; RELOCK -> PRST; reserved -> RESP with OK.
- SETUP: apb_sel=1, apb_en=0, addr/write/wdata driven from latch -> ACCESS.
- ACCESS: apb_sel=1, apb_en=1. apb_ready=1 -> capture apb_rdata (READ only), status OK -> RESP. Cycle counter reaches APB_TIMEOUT without ready -> status APB_TIMEOUT, rdata 0 -> RESP.
- PRST: pll_rst=1 for exactly RST_CYC cycles -> WLOCK.
- WLOCK: pll_rst=0; locked=1 -> OK -> RESP; LOCK_TIMEOUT cycles elapse -> LOCK_TIMEOUT -> RESP.
- RESP: rsp_valid=1 for one cycle -> IDLE. rsp_status/rsp_rdata hold until next RESP.
- apb_addr/apb_wdata/apb_write hold last value outside transfers; apb_sel/apb_en are 0 in every state except SETUP/ACCESS.
- locked = pll_lock through a 2-flop synchronizer; lock loss outside WLOCK is reported on locked only.
- Counters sized $clog2(max+1), cleared on every state entry, saturating.

## Timing
- Reset: state IDLE, cmd_ready=1 after reset release, rsp_valid=0, rsp_status=0, rsp_rdata=0, apb_sel/en/write=0, apb_addr=0, apb_wdata=0, pll_rst=0, locked=0.
- Zero-wait transfer: accept cycle N, SETUP N+1, ACCESS N+2, RESP (rsp_valid) N+3, cmd_ready N+4. Each wait cycle adds one.
- cmd_ready=0 from accept+1 until back in IDLE; no command pipelining.
- Lock synchronizer latency 2 cycles; lock already high during PRST does not count (wait restarts in WLOCK).
- Reset mid-transfer: APB signals and pll_rst drop immediately (async); no response issued.

## Structure
- pll_reconfig_pkg: op codes, status codes, state enum, address width 5 and data width 16 constants.
- Sub-module sync_2ff for pll_lock; the rest is one FSM plus one shared cycle counter.

## Test plan
- WRITE addr 5'h03 data 16'h0078, apb_ready high in first ACCESS -> sel/en pattern SETUP then ACCESS, rsp_valid at N+3, status 0.
- READ addr 5'h11, responder returns 16'hA5C3 after 3 wait cycles -> rsp_rdata 16'hA5C3 at N+6, status 0.
- READ with apb_ready stuck 0 -> after 64 ACCESS cycles sel/en drop, status 1, rdata 0.
- RELOCK, model lock asserting 100 cycles after pll_rst fall -> pll_rst high exactly 16 cycles, status 0, locked=1.
- RELOCK with lock never asserting (LOCK_TIMEOUT=200 override) -> status 2 after 200 WLOCK cycles.
- apb_rst_n pulsed low during ACCESS -> all outputs to reset values same cycle, no rsp_valid, next command works.

Source files
------------

// File: rtl/pll_reconfig_ctrl_pkg.sv
// Shared types and constants for the GPLL dynamic-reconfiguration controller.
// Imported by the APB interface, the controller top and the bench.
package pll_reconfig_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int SYNC_LAT = 2;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_READ   = 2'd1,
        OP_RELOCK = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_APB_TO  = 2'd1,
        ST_LOCK_TO = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_PRST,
        S_WLOCK,
        S_RESP
    } state_e;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// APB bus between the reconfiguration controller and the GPLL wrapper.
// master = initiator (controller), slave = GPLL register port.
interface pll_apb_if;
    import pll_reconfig_pkg::*;

    logic              apb_sel;
    logic              apb_en;
    logic              apb_write;
    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_wdata;
    logic [DATA_W-1:0] apb_rdata;
    logic              apb_ready;

    modport master (
        output apb_sel, apb_en, apb_write,
        output apb_addr, apb_wdata,
        input  apb_rdata, apb_ready
    );

    modport slave (
        input  apb_sel, apb_en, apb_write,
        input  apb_addr, apb_wdata,
        output apb_rdata, apb_ready
    );

endinterface

// File: rtl/pll_reconfig_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous GPLL lock into apb_clk.
// Resets to 0 so locked reads low until a real lock is observed.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// APB initiator for GPLL reconfiguration: one APB transfer or one
// reset/lock sequence per command, one bounded-time response each.
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter int APB_TIMEOUT  = 64,
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              apb_clk,
    input  logic              apb_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_rdata,
    pll_apb_if.master         apb,
    output logic              pll_rst,
    input  logic              pll_lock,
    output logic              locked
);

    localparam int CNT_MAX = max3(APB_TIMEOUT, RST_CYC, LOCK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] APB_LAST  = CNT_W'(APB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_MIN  = CNT_W'(SYNC_LAT);

    state_e            state;
    state_e            state_n;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q;
    op_e               cmd_op_e;
    logic              accept;
    logic              rsp_load;
    status_e           status_n;
    logic [DATA_W-1:0] rdata_n;

    assign cmd_op_e  = op_e'(cmd_op);
    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == S_RESP);
    assign pll_rst   = (state == S_PRST);

    assign apb.apb_sel = (state == S_SETUP) || (state == S_ACCESS);
    assign apb.apb_en  = (state == S_ACCESS);

    sync_2ff u_lock_sync (
        .clk   (apb_clk),
        .rst_n (apb_rst_n),
        .d     (pll_lock),
        .q     (locked)
    );

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_n  = state;
        rsp_load = 1'b0;
        status_n = ST_OK;
        rdata_n  = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd_op_e)
                        OP_WRITE,
                        OP_READ:   state_n = S_SETUP;
                        OP_RELOCK: state_n = S_PRST;
                        default: begin
                            state_n  = S_RESP;
                            rsp_load = 1'b1;
                        end
                    endcase
                end
            end
            S_SETUP: state_n = S_ACCESS;
            S_ACCESS: begin
                if (apb.apb_ready) begin
                    state_n  = S_RESP;
                    rsp_load = 1'b1;
                    if (op_q == OP_READ)
                        rdata_n = apb.apb_rdata;
                end else if (cnt == APB_LAST) begin
                    state_n  = S_RESP;
                    rsp_load = 1'b1;
                    status_n = ST_APB_TO;
                end
            end
            S_PRST: begin
                if (cnt == RST_LAST)
                    state_n = S_WLOCK;
            end
            S_WLOCK: begin
                // the first SYNC_LAT samples still reflect lock from before reset
                if (locked && cnt >= LOCK_MIN) begin
                    state_n  = S_RESP;
                    rsp_load = 1'b1;
                end else if (cnt == LOCK_LAST) begin
                    state_n  = S_RESP;
                    rsp_load = 1'b1;
                    status_n = ST_LOCK_TO;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            op_q          <= OP_WRITE;
            apb.apb_addr  <= '0;
            apb.apb_wdata <= '0;
            apb.apb_write <= 1'b0;
            rsp_status    <= 2'd0;
            rsp_rdata     <= '0;
        end else begin
            if (accept) begin
                op_q <= cmd_op_e;
                if (cmd_op_e == OP_WRITE || cmd_op_e == OP_READ) begin
                    apb.apb_addr  <= cmd_addr;
                    apb.apb_wdata <= cmd_wdata;
                    apb.apb_write <= (cmd_op_e == OP_WRITE);
                end
            end
            if (rsp_load) begin
                rsp_status <= status_n;
                rsp_rdata  <= rdata_n;
            end
        end
    end

endmodule
